// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths, register
// count, the hard-wired zero register index and the write-port priority helper.
package regfile_pkg;

    localparam int unsigned DefDataWidth  = 32;
    localparam int unsigned DefAddrWidth  = 5;
    localparam int unsigned NumRegs       = 2 ** DefAddrWidth;
    localparam int unsigned RegZero       = 0;

    // Widest write-port hit vector the priority helper accepts.
    localparam int unsigned MaxWritePorts = 16;

    // Index of the youngest (highest-numbered) asserted write port.
    // Returns 0 when no bit is set; callers qualify the result with |hit.
    function automatic int unsigned prio_write_sel(input logic [MaxWritePorts-1:0] hit);
        int unsigned sel;
        sel = 0;
        for (int unsigned i = 0; i < MaxWritePorts; i++) begin
            if (hit[i]) begin
                sel = i;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register file. Issue reserves a destination, writeback
// releases it, flush clears everything. busy_count_o is the registered popcount
// of the next-state busy vector. Register 0 is never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
    parameter int unsigned WRITE_PORTS = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              reserve_en_i,
    input  logic [ADDR_WIDTH-1:0]             reserve_addr_i,
    input  logic                              flush_i,
    input  logic [WRITE_PORTS-1:0]            write_en_i,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_addr_i,
    output logic [(2**ADDR_WIDTH)-1:0]        busy_o,
    output logic [ADDR_WIDTH:0]               busy_count_o
);

    localparam int unsigned Regs = 2 ** ADDR_WIDTH;

    logic [Regs-1:0]     busy_q;
    logic [Regs-1:0]     busy_d;
    logic [Regs-1:0]     wr_hit;
    logic [ADDR_WIDTH:0] count_q;
    logic [ADDR_WIDTH:0] count_d;

    // Per-register release request from any write port this cycle.
    always_comb begin
        wr_hit = '0;
        for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
            if (write_en_i[w]) begin
                wr_hit[write_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
            end
        end
    end

    // Busy next-state: flush beats reserve, reserve beats release (new producer).
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 0; r < Regs; r++) begin
            if (r == RegZero) begin
                busy_d[r] = 1'b0;
            end else if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (reserve_en_i && (reserve_addr_i == ADDR_WIDTH'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    // Popcount of the next-state vector so the count matches busy_q after the edge.
    always_comb begin
        count_d = '0;
        for (int unsigned r = 0; r < Regs; r++) begin
            count_d = count_d + (ADDR_WIDTH + 1)'(busy_d[r]);
        end
    end

    // Scoreboard state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = count_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port GPR file: READ_PORTS combinational read ports, WRITE_PORTS
// synchronous write ports (higher index = younger, wins on address clash),
// plus a per-register busy scoreboard. Register 0 reads as zero and is never busy.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read of a register
// being written in the same cycle returns the youngest write data instead of the
// stored value.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
    parameter int unsigned READ_PORTS  = 4,
    parameter int unsigned WRITE_PORTS = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [READ_PORTS-1:0]             read_en,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]  read_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  read_data,
    output logic [READ_PORTS-1:0]             read_busy,
    input  logic [WRITE_PORTS-1:0]            write_en,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_addr,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] write_data,
    input  logic                              reserve_en,
    input  logic [ADDR_WIDTH-1:0]             reserve_addr,
    input  logic                              flush,
    output logic [ADDR_WIDTH:0]               busy_count
);

    localparam int unsigned Regs = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Regs];
    logic [DATA_WIDTH-1:0] mem_d [Regs];
    logic [Regs-1:0]       busy;

    // Storage next-state: ascending port order lets the youngest port win a clash.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
            if (write_en[w] && (write_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                mem_d[write_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] =
                    write_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Register storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WRITE_PORTS (WRITE_PORTS)
    ) u_scoreboard (
        .clk_i          (clk),
        .rst_i          (rst),
        .reserve_en_i   (reserve_en),
        .reserve_addr_i (reserve_addr),
        .flush_i        (flush),
        .write_en_i     (write_en),
        .write_addr_i   (write_addr),
        .busy_o         (busy),
        .busy_count_o   (busy_count)
    );

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0]  raddr;
        logic [WRITE_PORTS-1:0] hit;
        logic [DATA_WIDTH-1:0]  data_p;
        logic                   busy_p;

        assign raddr = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Which write ports target this read address in the current cycle.
        always_comb begin
            hit = '0;
            for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
                hit[w] = write_en[w] && (write_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == raddr);
            end
        end

`ifdef REGFILE_BYPASS_EN
        int unsigned sel;

        // Youngest matching write port for the bypass path (WRITE_PORTS <= MaxWritePorts).
        always_comb begin
            sel = prio_write_sel(MaxWritePorts'(hit));
        end
`endif

        // Read mux: zero for disabled port, r0 or reset; a writeback in flight
        // clears the busy indication even though storage updates next edge.
        always_comb begin
            data_p = '0;
            busy_p = 1'b0;
            if (!rst && read_en[p] && (raddr != '0)) begin
                data_p = mem_q[raddr];
`ifdef REGFILE_BYPASS_EN
                if (|hit) begin
                    data_p = write_data[sel*DATA_WIDTH +: DATA_WIDTH];
                end
`endif
                busy_p = busy[raddr] & ~(|hit);
            end
        end

        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = data_p;
        assign read_busy[p]                          = busy_p;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default parameters). Expected
// values are hand-computed; bypass-dependent expectations follow REGFILE_BYPASS_EN.
module tb_reg_file_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned RP = 4;
    localparam int unsigned WP = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [RP-1:0]     read_en;
    logic [RP*AW-1:0]  read_addr;
    logic [RP*DW-1:0]  read_data;
    logic [RP-1:0]     read_busy;
    logic [WP-1:0]     write_en;
    logic [WP*AW-1:0]  write_addr;
    logic [WP*DW-1:0]  write_data;
    logic              reserve_en;
    logic [AW-1:0]     reserve_addr;
    logic              flush;
    logic [AW:0]       busy_count;

    int n_chk;
    int n_bad;

    reg_file_mp #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_PORTS  (RP),
        .WRITE_PORTS (WP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .read_en      (read_en),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .read_busy    (read_busy),
        .write_en     (write_en),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .reserve_en   (reserve_en),
        .reserve_addr (reserve_addr),
        .flush        (flush),
        .busy_count   (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr();
        rst          = 1'b0;
        read_en      = '0;
        read_addr    = '0;
        write_en     = '0;
        write_addr   = '0;
        write_data   = '0;
        reserve_en   = 1'b0;
        reserve_addr = '0;
        flush        = 1'b0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        read_en[p]          = 1'b1;
        read_addr[p*AW +: AW] = a;
    endtask

    task automatic wr(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_en[w]            = 1'b1;
        write_addr[w*AW +: AW] = a;
        write_data[w*DW +: DW] = d;
    endtask

    task automatic rsv(input logic [AW-1:0] a);
        reserve_en   = 1'b1;
        reserve_addr = a;
    endtask

    // Advance one edge, then clear inputs so each cycle is set up from scratch.
    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    function automatic logic [DW-1:0] rdat(input int p);
        return read_data[p*DW +: DW];
    endfunction

    initial begin
        n_chk = 0;
        n_bad = 0;
        clr();

        // Reset state
        rst = 1'b1;
        rd(0, 5'd5);
        #1;
        check("rst_rd_data", rdat(0), 32'h0);
        check("rst_rd_busy", 32'(read_busy[0]), 32'h0);
        step();
        check("rst_count", 32'(busy_count), 32'h0);

        // 1: write r5, then reset clears it
        wr(0, 5'd5, 32'hDEAD);
        step();
        rd(0, 5'd5);
        #1;
        check("t1_r5_written", rdat(0), 32'hDEAD);
        rd(1, 5'd5);
        read_en[0] = 1'b0;
        #1;
        check("t1_rd_en_off", rdat(0), 32'h0);
        rst = 1'b1;
        #1;
        check("t1_rd_during_rst", rdat(1), 32'h0);
        step();
        rd(0, 5'd5);
        #1;
        check("t1_r5_after_rst", rdat(0), 32'h0);
        check("t1_count", 32'(busy_count), 32'h0);

        // 2: write priority
        wr(0, 5'd3, 32'h1111);
        wr(1, 5'd3, 32'h2222);
        rd(1, 5'd3);
        #1;
        check("t2_same_cycle", rdat(1), Bypass ? 32'h2222 : 32'h0);
        step();
        rd(2, 5'd3);
        #1;
        check("t2_r3", rdat(2), 32'h2222);
        // single older-port write later is still visible
        wr(0, 5'd3, 32'h3333);
        step();
        rd(3, 5'd3);
        #1;
        check("t2_r3_w0", rdat(3), 32'h3333);

        // 3: zero register
        wr(1, 5'd0, 32'hFFFF);
        rsv(5'd0);
        rd(2, 5'd0);
        #1;
        check("t3_r0_same", rdat(2), 32'h0);
        check("t3_r0_busy_same", 32'(read_busy[2]), 32'h0);
        step();
        rd(2, 5'd0);
        #1;
        check("t3_r0_data", rdat(2), 32'h0);
        check("t3_r0_busy", 32'(read_busy[2]), 32'h0);
        check("t3_count", 32'(busy_count), 32'h0);

        // 4: scoreboard reserve/release on r7
        wr(0, 5'd7, 32'h44);
        step();
        rsv(5'd7);
        rd(0, 5'd7);
        #1;
        check("t4_busy_same_rsv", 32'(read_busy[0]), 32'h0);
        step();
        rd(0, 5'd7);
        #1;
        check("t4_busy", 32'(read_busy[0]), 32'h1);
        check("t4_count1", 32'(busy_count), 32'h1);
        step();
        rd(0, 5'd7);
        #1;
        check("t4_busy_hold", 32'(read_busy[0]), 32'h1);
        wr(1, 5'd7, 32'h55);
        #1;
        check("t4_busy_wb", 32'(read_busy[0]), 32'h0);
        check("t4_data_wb", rdat(0), Bypass ? 32'h55 : 32'h44);
        step();
        rd(1, 5'd7);
        #1;
        check("t4_count0", 32'(busy_count), 32'h0);
        check("t4_r7", rdat(1), 32'h55);
        check("t4_r7_busy", 32'(read_busy[1]), 32'h0);

        // 5: reserve beats same-cycle write
        rsv(5'd9);
        step();
        wr(0, 5'd9, 32'hAAAA);
        rsv(5'd9);
        rd(0, 5'd9);
        #1;
        check("t5_busy_same", 32'(read_busy[0]), 32'h0);
        step();
        rd(0, 5'd9);
        #1;
        check("t5_busy", 32'(read_busy[0]), 32'h1);
        check("t5_data", rdat(0), 32'hAAAA);
        check("t5_count", 32'(busy_count), 32'h1);
        wr(1, 5'd9, 32'hBBBB);
        step();
        check("t5_count0", 32'(busy_count), 32'h0);

        // 6: flush
        rsv(5'd1);
        step();
        rsv(5'd2);
        step();
        rsv(5'd4);
        step();
        check("t6_count3", 32'(busy_count), 32'h3);
        rd(0, 5'd1);
        rd(1, 5'd2);
        rd(2, 5'd4);
        #1;
        check("t6_busy_r4", 32'(read_busy[2]), 32'h1);
        check("t6_busy_vec", 32'(read_busy), 32'h7);
        flush = 1'b1;
        rsv(5'd6);
        wr(0, 5'd10, 32'h77);
        step();
        rd(0, 5'd1);
        rd(1, 5'd2);
        rd(2, 5'd4);
        rd(3, 5'd6);
        #1;
        check("t6_count0", 32'(busy_count), 32'h0);
        check("t6_busy_all", 32'(read_busy), 32'h0);
        rd(3, 5'd10);
        #1;
        check("t6_write_lands", rdat(3), 32'h77);

        // 7: reset dominates write/reserve/flush
        rsv(5'd11);
        step();
        check("t7_count1", 32'(busy_count), 32'h1);
        rst = 1'b1;
        rsv(5'd12);
        wr(0, 5'd12, 32'h99);
        flush = 1'b1;
        step();
        rd(0, 5'd12);
        rd(1, 5'd11);
        rd(2, 5'd10);
        #1;
        check("t7_count0", 32'(busy_count), 32'h0);
        check("t7_r12", rdat(0), 32'h0);
        check("t7_r11_busy", 32'(read_busy[1]), 32'h0);
        check("t7_r10", rdat(2), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
